muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit in the execute stage, beside the ALU, fed by the same
//   register-file operands a/b. Runs MIPS mult/multu/div/divu over WIDTH+1 cycles and
//   holds the results in HI/LO. Also services mthi/mtlo writes.
//   hi/lo feed the write-back mux for mfhi/mflo. The controller stalls the PC while busy=1.
// PARAMETERS
//   WIDTH  32  operand width; HI and LO are WIDTH bits each
// PORTS
//   clk    in   1      clock; all state changes on rising edge
//   rst_n  in   1      synchronous reset, active low
//   a      in   WIDTH  operand rs: multiplicand / dividend / mthi-mtlo data
//   b      in   WIDTH  operand rt: multiplier / divisor
//   op     in   3      000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo
//   start  in   1      request; op, a and b are sampled when start=1 and busy=0
//   busy   out  1      operation in progress
//   done   out  1      one-cycle pulse: new HI/LO are valid
//   hi     out  WIDTH  HI register (product high half / remainder)
//   lo     out  WIDTH  LO register (product low half / quotient)
// BEHAVIOUR
//   Reset: on an edge with rst_n=0, hi=0, lo=0, busy=0, done=0, FSM=IDLE.
//     Reset wins over everything and aborts any operation in flight.
//   FSM: IDLE -> RUN (WIDTH cycles, one shift-add or restore-subtract step each) -> FIX -> IDLE.
//   Accept: at an edge with start=1, busy=0 and op in {001..100}:
//     - latch magnitudes (signed ops: |a|, |b|; unsigned ops: raw values) and result signs
//     - busy=1 from the next cycle; iteration counter=0; FSM=RUN
//   RUN: counter increments every cycle. After WIDTH steps, go to FIX.
//   FIX: apply signs.
//     - mult: negate the 2*WIDTH product if sign(a)^sign(b)
//     - div: negate quotient if sign(a)^sign(b); negate remainder if sign(a)
//       (truncating division)
//     - write hi/lo at the FIX edge; FSM=IDLE
//   Cycle after FIX edge: busy=0, done=1, new hi/lo visible. Accept-to-done latency is
//     WIDTH+2 edges; busy is high for WIDTH+1 cycles.
//   hi/lo hold their previous values for the whole operation; no partial results appear.
//   start while busy=1: ignored; the operation in flight is unaffected.
//   mthi/mtlo with start=1 and busy=0: at the next edge hi<=a (or lo<=a).
//     No busy and no done; the other register is unchanged.
//   op=000 or op=111 with start: no effect.
//   Divide by zero (b=0, div or divu): full latency; lo = all ones, hi = a (raw).
//   Signed overflow (div, a=MIN_INT, b=-1): lo = MIN_INT, hi = 0.
//   done is 0 in every cycle other than the single post-FIX cycle.
//   Multiplication is exact over 2*WIDTH bits; unsigned ops never sign-extend.
// TESTING
//   1 Reset: rst_n=0 mid-RUN of a multu -> next cycle hi=0, lo=0, busy=0, done=0;
//     later ops work normally.
//   2 multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 34 edges hi=0xFFFFFFFE, lo=0x00000001,
//     done pulses once.
//   3 mult a=-7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB;
//     mult a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0.
//   4 div a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1);
//     divu a=7, b=2 -> lo=3, hi=1.
//   5 Corners: divu a=5, b=0 -> lo=0xFFFFFFFF, hi=5;
//     div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
//   6 Busy and mt rules: start mult while busy -> ignored, first result intact;
//     mthi a=0x1234 when idle -> hi=0x1234 next cycle, lo unchanged, busy/done stay 0.

Source files
------------

// File: rtl/muldiv_if.sv
// Operand/request and result bundle between the execute-stage controller and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output a, b, op, start, input busy, done, hi, lo);
  modport slave  (input a, b, op, start, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS mult/multu/div/divu unit holding HI/LO; one shift-add or
// restore-subtract step per cycle on magnitudes, signs applied in a final FIX cycle.
//
// state | meaning
// IDLE  | waiting for start; mthi/mtlo serviced here
// RUN   | WIDTH iteration steps on the magnitude datapath
// FIX   | sign correction and HI/LO write
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic               b_zero;
  logic               done_q;

  logic               idle;
  logic               is_signed_op;
  logic               is_div_op;
  logic               arith_op;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] p_step;
  logic [2*WIDTH-1:0] p_neg;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  assign idle         = (state == IDLE);
  assign is_signed_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);
  assign is_div_op    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
  assign arith_op     = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  assign sa           = bus.a[WIDTH-1] & is_signed_op;
  assign sb           = bus.b[WIDTH-1] & is_signed_op;
  assign mag_a        = sa ? -bus.a : bus.a;
  assign mag_b        = sb ? -bus.b : bus.b;

  // Multiply keeps {partial product, remaining multiplier bits} in p; divide keeps
  // {partial remainder, dividend-shifting-into-quotient} in p.
  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    div_trial = p[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    p_step    = p;
    if (is_div) begin
      if (!div_trial[WIDTH])
        p_step = {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
      else
        p_step = {p[2*WIDTH-2:0], 1'b0};
    end else begin
      p_step = {mul_sum, p[WIDTH-1:1]};
    end
  end

  assign p_neg = -p;
  assign quo   = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
  assign rem   = neg_r ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && arith_op) begin
            state  <= RUN;
            cnt    <= '0;
            is_div <= is_div_op;
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            a_raw  <= bus.a;
            b_zero <= (bus.b == '0);
            if (is_div_op) begin
              p    <= {{WIDTH{1'b0}}, mag_a};
              opnd <= mag_b;
            end else begin
              p    <= {{WIDTH{1'b0}}, mag_b};
              opnd <= mag_a;
            end
          end else if (bus.start && bus.op == OP_MTHI) begin
            hi_q <= bus.a;
          end else if (bus.start && bus.op == OP_MTLO) begin
            lo_q <= bus.a;
          end
        end
        RUN: begin
          p   <= p_step;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1))
            state <= FIX;
        end
        FIX: begin
          state  <= IDLE;
          done_q <= 1'b1;
          if (is_div) begin
            if (b_zero) begin
              lo_q <= '1;
              hi_q <= a_raw;
            end else begin
              lo_q <= quo;
              hi_q <= rem;
            end
          end else begin
            {hi_q, lo_q} <= neg_q ? p_neg : p;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = !idle;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed vector bench for muldiv_unit: result tables plus latency, busy, reset and mt* sequences.
module tb_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [W-1:0] exp_hi;
  logic [W-1:0] exp_lo;

  muldiv_if #(.WIDTH(W)) bus ();
  muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input int idx, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s[%0d]: actual=%0h required=%0h", nm, idx, act, req);
    end
  endtask

  // Runs one arithmetic op; optionally fires a mult and an mthi while busy.
  task automatic run_op(input int idx, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int intrude_at);
    int lat;
    int busy_cyc;
    logic hold_ok;
    @(negedge clk);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1; busy_cyc = 0; hold_ok = 1'b1;
    while (!bus.done && lat < 100) begin
      if (bus.busy) busy_cyc++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) hold_ok = 1'b0;
      if (lat == intrude_at) begin
        bus.op = 3'd1; bus.a = 32'd100; bus.b = 32'd100; bus.start = 1'b1;
      end else if (lat == intrude_at + 3) begin
        bus.op = 3'd5; bus.a = 32'hDEAD; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.start = 1'b0;
    check("latency", idx, 64'(lat), 64'(W + 2));
    check("busy_cycles", idx, 64'(busy_cyc), 64'(W + 1));
    check("hold", idx, 64'(hold_ok), 64'd1);
    check("busy_at_done", idx, 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    check("done_single", idx, 64'(bus.done), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{3'd1, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[3]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{3'd4, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[5]  = '{3'd4, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
    vecs[6]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{3'd3, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
    vecs[9]  = '{3'd2, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};
    vecs[10] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[11] = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[12] = '{3'd3, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};

    bus.a = '0; bus.b = '0; bus.op = 3'd0; bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 0, 64'(bus.hi), 64'd0);
    check("rst_lo", 0, 64'(bus.lo), 64'd0);
    check("rst_busy", 0, 64'(bus.busy), 64'd0);
    check("rst_done", 0, 64'(bus.done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_hi = '0; exp_lo = '0;

    // mthi / mtlo when idle: only the addressed register moves, no busy/done
    @(negedge clk);
    bus.op = 3'd5; bus.a = 32'h1234; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("mthi_hi", 0, 64'(bus.hi), 64'h1234);
    check("mthi_lo", 0, 64'(bus.lo), 64'd0);
    check("mthi_busy", 0, 64'(bus.busy), 64'd0);
    check("mthi_done", 0, 64'(bus.done), 64'd0);
    @(negedge clk);
    bus.op = 3'd6; bus.a = 32'h5555; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("mtlo_lo", 0, 64'(bus.lo), 64'h5555);
    check("mtlo_hi", 0, 64'(bus.hi), 64'h1234);
    check("mtlo_done", 0, 64'(bus.done), 64'd0);

    // op 000 and 111 are no-ops
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.op = (k == 0) ? 3'd0 : 3'd7; bus.a = 32'hBEEF; bus.b = 32'd3; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      check("nop_busy", k, 64'(bus.busy), 64'd0);
      check("nop_hi", k, 64'(bus.hi), 64'h1234);
      check("nop_lo", k, 64'(bus.lo), 64'h5555);
    end

    // reset mid-RUN of a multu
    @(negedge clk);
    bus.op = 3'd2; bus.a = 32'hFFFFFFFF; bus.b = 32'h3; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_hi", 0, 64'(bus.hi), 64'd0);
    check("midrst_lo", 0, 64'(bus.lo), 64'd0);
    check("midrst_busy", 0, 64'(bus.busy), 64'd0);
    check("midrst_done", 0, 64'(bus.done), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (W + 4) @(posedge clk);
    #1;
    check("postrst_hi", 0, 64'(bus.hi), 64'd0);
    check("postrst_busy", 0, 64'(bus.busy), 64'd0);
    exp_hi = '0; exp_lo = '0;

    for (int i = 0; i < 13; i++) begin
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, 0);
      check("hi", i, 64'(bus.hi), 64'(vecs[i].hi));
      check("lo", i, 64'(bus.lo), 64'(vecs[i].lo));
      exp_hi = vecs[i].hi; exp_lo = vecs[i].lo;
    end

    // start while busy is ignored: mult 3*5 with a mult and an mthi fired mid-run
    run_op(100, 3'd1, 32'd3, 32'd5, 5);
    check("busy_ign_hi", 100, 64'(bus.hi), 64'd0);
    check("busy_ign_lo", 100, 64'(bus.lo), 64'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
